// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback engine: FSM states, control-word
// bit positions and the silence level.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    DRAIN
  } state_t;

  localparam int START_BIT = 31;
  localparam int STOP_BIT  = 30;
  localparam int LOOP_BIT  = 29;
  localparam int VOL_MSB   = 28;
  localparam int VOL_LSB   = 27;

  localparam logic [7:0] SILENCE = 8'h80;

endpackage

// File: rtl/audio_pwm.sv
// 8-bit free-running PWM: output is high while the counter is below duty,
// so 0 gives a flat low and 0xFF gives 255/256 high.
module audio_pwm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty,
  output logic       pwm_out
);

  logic [7:0] r_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p     <= '0;
      pwm_out <= 1'b0;
    end else begin
      r_p     <= r_p + 8'd1;
      pwm_out <= (r_p < duty);
    end
  end

endmodule

// File: rtl/audio_player.sv
// Sample-playback engine: fetches 8-bit samples from the audio buffer at a
// fixed rate and drives a PWM pin. Optional volume shift under AUDIO_VOLUME_EN.
module audio_player
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 8_000,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_we,
  input  logic [31:0]       ctrl_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              pwm_out,
  output logic              amp_en,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = $clog2(DIV);

  if (DIV < 4) begin : g_div_check
    $error("audio_player: CLK_HZ/SAMPLE_HZ must be at least 4");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_len;
  logic              r_loop;
  logic [DIV_W-1:0]  r_div;
  logic [7:0]        r_cur;
  logic [7:0]        r_next;
  logic              r_busy;
  logic              r_done;
  logic              w_tick;
  logic              w_stop;
  logic              w_start;
  logic [7:0]        w_eff;
  logic              w_unused;

  assign w_tick   = (r_div == DIV_W'(DIV - 1));
  assign w_stop   = ctrl_we && ctrl_data[STOP_BIT];
  assign w_start  = ctrl_we && ctrl_data[START_BIT] && (ctrl_data[ADDR_W-1:0] != '0);
  assign w_unused = ^ctrl_data;

`ifdef AUDIO_VOLUME_EN
  logic [1:0]        r_vol;
  logic signed [7:0] w_centered;
  // Offset-binary to two's complement is a flip of the MSB, and back again.
  assign w_centered = signed'(r_cur ^ SILENCE);
  assign w_eff      = 8'(w_centered >>> r_vol) ^ SILENCE;
`else
  assign w_eff = r_cur;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_div   <= '0;
      r_cur   <= SILENCE;
      r_next  <= SILENCE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef AUDIO_VOLUME_EN
      r_vol   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE || w_tick) r_div <= '0;
      else                           r_div <= r_div + 1'b1;

      if (w_stop) begin
        r_state <= IDLE;
        r_cur   <= SILENCE;
        r_busy  <= 1'b0;
        r_div   <= '0;
      end else if (w_start) begin
        r_len   <= ctrl_data[ADDR_W-1:0];
        r_loop  <= ctrl_data[LOOP_BIT];
        r_idx   <= '0;
        r_div   <= '0;
        r_busy  <= 1'b1;
        r_state <= FETCH;
`ifdef AUDIO_VOLUME_EN
        r_vol   <= ctrl_data[VOL_MSB:VOL_LSB];
`endif
      end else begin
        case (r_state)
          FETCH: r_state <= WAIT;
          WAIT: begin
            r_next  <= rd_data;
            r_state <= PLAY;
          end
          PLAY: if (w_tick) begin
            r_cur <= r_next;
            if (r_idx < r_len - 1'b1) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= FETCH;
            end else if (r_loop) begin
              r_idx   <= '0;
              r_state <= FETCH;
            end else begin
              r_state <= DRAIN;
            end
          end
          DRAIN: if (w_tick) begin
            r_cur   <= SILENCE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_addr = r_idx;
  assign busy    = r_busy;
  assign amp_en  = r_busy;
  assign done    = r_done;
  assign status  = {r_busy, r_loop, 30'(r_idx)};

  audio_pwm u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty    (w_eff),
    .pwm_out (pwm_out)
  );

endmodule
